// File: rtl/vslc_scan_engine.sv
// Scan-cycle logic engine: latches inputs, runs a small bit-stack program
// from on-chip memory, then commits the output image in one cycle.
module vslc_scan_engine #(
  parameter int N_IN        = 8,
  parameter int N_OUT       = 8,
  parameter int PROG_DEPTH  = 16,
  parameter int STACK_DEPTH = 8,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in_bits,
  output logic [N_OUT-1:0] out_bits,
  input  logic             run,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [7:0]       prog_data,
  output logic             busy,
  output logic             addr_strobe,
  output logic [AW-1:0]    pc,
  output logic             scan_done,
  output logic             fault,
  input  logic             fault_clr
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_EXEC, S_COMMIT, S_FAULT} state_t;
  typedef enum logic [2:0] {
    OP_END, OP_PUSH, OP_PUSHN, OP_AND, OP_OR, OP_NOT, OP_ST, OP_STP
  } op_t;

  state_t               state;
  logic [7:0]           prog_mem [PROG_DEPTH];
  logic [N_IN-1:0]      in_img;
  logic [N_OUT-1:0]     out_img;
  logic [STACK_DEPTH-1:0] stk, stk_nx;
  logic [SPW-1:0]       sp, sp_nx;

  logic [7:0]  word;
  op_t         op;
  logic        src;
  logic [3:0]  idx;
  logic [15:0] in_pad, out_pad;
  logic        opnd, wr_en, op_fault, last_word;

  assign word        = prog_mem[pc];
  assign op          = op_t'(word[7:5]);
  assign src         = word[4];
  assign idx         = word[3:0];
  assign last_word   = (pc == AW'(PROG_DEPTH - 1));
  assign busy        = (state == S_LATCH) || (state == S_EXEC) || (state == S_COMMIT);
  assign addr_strobe = (state == S_EXEC);
  assign scan_done   = (state == S_COMMIT);

  // Program memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE || state == S_FAULT))
      prog_mem[prog_addr] <= prog_data;
  end

  // Stack top lives in stk[0]; push shifts left, pop shifts right.
  always_comb begin
    in_pad             = '0;
    in_pad[N_IN-1:0]   = in_img;
    out_pad            = '0;
    out_pad[N_OUT-1:0] = out_img;
    opnd     = src ? out_pad[idx] : in_pad[idx];
    stk_nx   = stk;
    sp_nx    = sp;
    wr_en    = 1'b0;
    op_fault = 1'b0;
    case (op)
      OP_PUSH, OP_PUSHN: begin
        if (sp == SPW'(STACK_DEPTH)) op_fault = 1'b1;
        else begin
          stk_nx = {stk[STACK_DEPTH-2:0], opnd ^ (op == OP_PUSHN)};
          sp_nx  = sp + 1'b1;
        end
      end
      OP_AND, OP_OR: begin
        if (sp < SPW'(2)) op_fault = 1'b1;
        else begin
          stk_nx    = stk >> 1;
          stk_nx[0] = (op == OP_AND) ? (stk[1] & stk[0]) : (stk[1] | stk[0]);
          sp_nx     = sp - 1'b1;
        end
      end
      OP_NOT: begin
        if (sp == '0) op_fault = 1'b1;
        else stk_nx[0] = ~stk[0];
      end
      OP_ST: begin
        if (sp == '0) op_fault = 1'b1;
        else wr_en = 1'b1;
      end
      OP_STP: begin
        if (sp == '0) op_fault = 1'b1;
        else begin
          wr_en  = 1'b1;
          stk_nx = stk >> 1;
          sp_nx  = sp - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      out_bits <= '0;
      out_img  <= '0;
      in_img   <= '0;
      pc       <= '0;
      sp       <= '0;
      stk      <= '0;
      fault    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_LATCH;
        S_LATCH: begin
          in_img <= in_bits;
          sp     <= '0;
          pc     <= '0;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          if (op_fault) begin
            state    <= S_FAULT;
            fault    <= 1'b1;
            out_bits <= '0;
          end else if (op == OP_END) begin
            state <= S_COMMIT;
          end else begin
            stk <= stk_nx;
            sp  <= sp_nx;
            // Out-of-range store indexes match no bit and are dropped.
            for (int unsigned i = 0; i < N_OUT; i++)
              if (wr_en && 32'(idx) == i) out_img[i] <= stk[0];
            if (last_word) state <= S_COMMIT;
            else           pc    <= pc + 1'b1;
          end
        end
        S_COMMIT: begin
          out_bits <= out_img;
          state    <= run ? S_LATCH : S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr) begin
            fault <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vslc_scan_engine.sv
// Scoreboard bench for vslc_scan_engine: directed programs push expected
// scan/fault results; a monitor pops and compares on scan_done or fault.
module tb_vslc_scan_engine;

  localparam int AW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_bits;
  logic [7:0] out_bits;
  logic       run, prog_we, busy, addr_strobe, scan_done, fault, fault_clr;
  logic [AW-1:0] prog_addr, pc;
  logic [7:0] prog_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         is_fault;
    logic [7:0] val;
    logic [3:0] pcv;
  } exp_t;
  exp_t exp_q[$];

  vslc_scan_engine #(.N_IN(8), .N_OUT(8), .PROG_DEPTH(16), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_bits(in_bits), .out_bits(out_bits), .run(run),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy),
    .addr_strobe(addr_strobe), .pc(pc), .scan_done(scan_done), .fault(fault),
    .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: scan results are compared the cycle after COMMIT, faults on entry.
  bit   pend = 0;
  exp_t pend_e;
  bit   fault_q = 0;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      n_tests++;
      if (out_bits !== pend_e.val) begin
        n_fail++;
        $display("FAIL scan_out: got %0h expected %0h", out_bits, pend_e.val);
      end
      pend = 0;
    end
    if (scan_done === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL scan_done: got unexpected pulse expected none");
      end else begin
        e = exp_q.pop_front();
        if (e.is_fault) begin
          n_fail++; $display("FAIL scan_done: got scan_done expected fault");
        end else begin
          pend = 1; pend_e = e;
        end
      end
    end
    if (fault === 1'b1 && !fault_q) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL fault: got unexpected fault expected none");
      end else begin
        e = exp_q.pop_front();
        if (!e.is_fault || out_bits !== 8'h00 || pc !== e.pcv) begin
          n_fail++;
          $display("FAIL fault: got out=%0h pc=%0d expected fault out=0 pc=%0d", out_bits, pc, e.pcv);
        end
      end
    end
    fault_q = (fault === 1'b1);
  end

  task automatic exp_scan(input logic [7:0] v);
    exp_t e; e.is_fault = 0; e.val = v; e.pcv = '0; exp_q.push_back(e);
  endtask

  task automatic exp_fault(input logic [3:0] p);
    exp_t e; e.is_fault = 1; e.val = '0; e.pcv = p; exp_q.push_back(e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); prog_we = 1; prog_addr = a; prog_data = d;
    @(negedge clk); prog_we = 0;
  endtask

  task automatic load(input logic [7:0] words[$]);
    foreach (words[i]) wr(4'(i), words[i]);
  endtask

  // Returns negedges waited; expiry is a failed comparison.
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); cyc++;
      if (scan_done) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_fault(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fault) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic clear_fault();
    @(negedge clk); fault_clr = 1;
    @(negedge clk); fault_clr = 0;
  endtask

  int cyc, cnt;
  logic [3:0] last_pc;
  logic [7:0] seal_in [6]  = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00};
  logic [7:0] seal_exp [6] = '{8'h08, 8'h09, 8'h09, 8'h09, 8'h08, 8'h08};

  initial begin
    rst_n = 0; run = 0; prog_we = 0; prog_addr = '0; prog_data = '0;
    in_bits = '0; fault_clr = 0;
    repeat (3) @(negedge clk);
    check("rst_out", out_bits, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", addr_strobe, 0);
    check("rst_done", scan_done, 0);
    check("rst_fault", fault, 0);
    check("rst_pc", pc, 0);
    rst_n = 1;

    // Single-shot AND program: 7-cycle scan, then back to IDLE.
    load('{8'h20, 8'h21, 8'h60, 8'hE3, 8'h00});
    in_bits = 8'h03;
    exp_scan(8'h08);
    @(negedge clk); run = 1; cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); run = 0;
      if (busy) cnt++;
      if (scan_done) break;
    end
    check("and_scan_len", cnt, 7);
    @(negedge clk);
    check("and_idle", busy, 0);

    // Reset with run held, then LATCH on the first edge after release.
    rst_n = 0; run = 1;
    repeat (2) @(negedge clk);
    check("rstrun_out", out_bits, 0);
    check("rstrun_busy", busy, 0);
    exp_scan(8'h08);
    rst_n = 1;
    @(negedge clk);
    check("rstrun_latch", busy, 1);
    run = 0;
    wait_idle("rstrun");

    // Stack underflow on AND: fault, run ignored, cleared by fault_clr.
    load('{8'h60, 8'h00});
    exp_fault(4'd0);
    @(negedge clk); run = 1;
    @(negedge clk); run = 0;
    wait_fault("and_fault");
    @(negedge clk); run = 1;
    repeat (2) @(negedge clk);
    run = 0;
    check("fault_hold", fault, 1);
    check("fault_nobusy", busy, 0);
    clear_fault();
    check("fault_clr", fault, 0);
    check("fault_clr_idle", busy, 0);

    // Seal-in with continuous run; bit 3 persists from earlier scans.
    load('{8'h20, 8'h30, 8'h80, 8'h41, 8'h60, 8'hF0, 8'h00});
    in_bits = seal_in[0];
    exp_scan(seal_exp[0]);
    @(negedge clk); run = 1;
    for (int s = 0; s < 6; s++) begin
      wait_done("seal", cyc);
      if (s > 0) check("seal_period", cyc, 9);
      if (s < 5) begin
        in_bits = seal_in[s+1];
        exp_scan(seal_exp[s+1]);
      end else run = 0;
    end
    wait_idle("seal");

    // Write to address 0 during EXEC is dropped: old PUSH in0 still runs.
    in_bits = 8'h00;
    exp_scan(8'h08);
    @(negedge clk); run = 1;
    for (int i = 0; i < 50 && !addr_strobe; i++) @(negedge clk);
    prog_we = 1; prog_addr = 4'd0; prog_data = 8'h00;
    @(negedge clk); prog_we = 0;
    wait_done("drop1", cyc);
    in_bits = 8'h01;
    exp_scan(8'h09);
    wait_done("drop2", cyc);
    run = 0;
    wait_idle("drop");

    // Full 16 words, no END; covers out-of-range indexes, NOT and ST.
    load('{8'h20, 8'hE1, 8'h29, 8'hE2, 8'h3C, 8'hE4, 8'h20, 8'hEC,
           8'h20, 8'hE5, 8'h20, 8'hE5, 8'h40, 8'hA0, 8'hC6, 8'hE7});
    in_bits = 8'hFF;
    exp_scan(8'hEB);
    @(negedge clk); run = 1; cnt = 0; last_pc = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); run = 0;
      if (busy) cnt++;
      if (addr_strobe) last_pc = pc;
      if (scan_done) break;
    end
    check("full_scan_len", cnt, 18);
    check("full_last_pc", last_pc, 15);
    wait_idle("full");

    // Nine pushes overflow; word 8 is written in the same cycle run starts.
    load('{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00});
    exp_fault(4'd8);
    @(negedge clk); run = 1; prog_we = 1; prog_addr = 4'd8; prog_data = 8'h20;
    @(negedge clk); run = 0; prog_we = 0;
    wait_fault("ovf");
    check("ovf_pc", pc, 8);
    clear_fault();
    check("ovf_clr", fault, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
